// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared state encoding, pin indices and lane helper for the program loader.
package program_loader_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } state_t;
  localparam int LOADER_UIO_STROBE = 0;
  localparam int LOADER_UIO_MODE   = 1;
  localparam int LOADER_UIO_ACK    = 2;
  localparam int INSTR_W           = 32;
  function automatic logic [INSTR_W-1:0] put_lane(input logic [INSTR_W-1:0] w, input logic [1:0] idx,
                                                  input logic [7:0] b);
    put_lane = w;
    put_lane[{idx, 3'b000} +: 8] = b;
  endfunction
endpackage

// File: rtl/program_loader_sync_edge.sv
// sync_edge: multi-flop synchroniser for an asynchronous pin with a registered rising-edge detect.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic d,
  output logic rise
);
  logic [STAGES-1:0] q;
  logic prev;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q    <= '0;
      prev <= 1'b0;
    end else if (ena) begin
      q    <= {q[STAGES-2:0], d};
      prev <= q[STAGES-1];
    end
  end
  assign rise = q[STAGES-1] & ~prev;
endmodule

// File: rtl/program_loader.sv
// program_loader: assembles host bytes into little-endian words and writes them to program memory,
// holding the CPU for the whole load session.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [7:0]         ld_data,
  input  logic               ld_strobe,
  input  logic               ld_mode,
  output logic               ld_ack,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic [ADDR_W:0]    word_count
);
  state_t state;
  logic [SYNC_STAGES-1:0] mode_q;
  logic [1:0] byte_idx;
  logic [INSTR_W-1:0] lanes;
  logic [INSTR_W-1:0] next_lanes;
  logic strobe_rise;
  logic mode;
  logic capture;
  sync_edge #(.STAGES(SYNC_STAGES)) u_strobe (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .d    (ld_strobe),
    .rise (strobe_rise)
  );
  assign mode = mode_q[SYNC_STAGES-1];
  // a mode fall in COLLECT beats a simultaneous strobe; COMMIT always finishes its byte
  assign capture = strobe_rise & ((state == COLLECT & mode) | state == COMMIT);
  assign next_lanes = put_lane(lanes, byte_idx, ld_data);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_q     <= '0;
      byte_idx   <= '0;
      lanes      <= '0;
      ld_ack     <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b0;
      word_count <= '0;
    end else if (ena) begin
      mode_q  <= {mode_q[SYNC_STAGES-2:0], ld_mode};
      imem_we <= 1'b0;
      if (capture) begin
        lanes    <= next_lanes;
        byte_idx <= byte_idx + 2'd1;
        ld_ack   <= ~ld_ack;
      end
      case (state)
        IDLE: begin
          cpu_hold <= mode;
          if (mode) begin
            state      <= COLLECT;
            imem_addr  <= '0;
            word_count <= '0;
            byte_idx   <= '0;
          end
        end
        COLLECT: begin
          if (!mode) state <= IDLE;
          else if (capture && byte_idx == 2'd3) begin
            state      <= COMMIT;
            imem_we    <= 1'b1;
            imem_wdata <= next_lanes;
          end
        end
        COMMIT: begin
          imem_addr  <= imem_addr + ADDR_W'(1);
          word_count <= word_count + {{ADDR_W{1'b0}}, ~word_count[ADDR_W]};
          state      <= mode ? COLLECT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed checks of byte capture, commit, abort, wrap, mode races, ena freeze and reset.
module tb_program_loader;
  localparam int AW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic [7:0] ld_data = 8'h00;
  logic ld_strobe = 1'b0;
  logic ld_mode = 1'b0;
  logic ld_ack, imem_we, cpu_hold;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [AW:0] word_count;
  int passed = 0;
  int total = 0;
  int acks = 0;
  logic ack_prev = 1'b0;
  logic [AW-1:0] wa[$];
  logic [31:0] wd[$];

  program_loader #(.ADDR_W(AW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ld_data(ld_data), .ld_strobe(ld_strobe), .ld_mode(ld_mode),
    .ld_ack(ld_ack), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // record every write and every ack toggle, sampled away from the rising edge
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
    if (ld_ack !== ack_prev) acks++;
    ack_prev = ld_ack;
  end

  function automatic logic [31:0] wd_at(input int i);
    return (i < wd.size()) ? wd[i] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [AW-1:0] wa_at(input int i);
    return (i < wa.size()) ? wa[i] : {AW{1'bx}};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic a;
    int k;
    @(negedge clk);
    a = ld_ack;
    ld_data = b;
    ld_strobe = 1'b1;
    k = 0;
    while (ld_ack === a && k < 12) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (ld_ack === a) $display("FAIL send_byte %02h: ld_ack=%b did not toggle within 12 cycles", b, ld_ack);
    else passed++;
    ld_strobe = 1'b0;
    tick(2);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
  endtask

  task automatic start_session;
    ld_mode = 1'b1;
    tick(5);
  endtask

  task automatic end_session;
    ld_mode = 1'b0;
    tick(6);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ld_mode = 1'b0;
    tick(3);
    total++; if (imem_we !== 1'b0) $display("FAIL reset_we got %b want 0", imem_we); else passed++;
    total++; if (cpu_hold !== 1'b0) $display("FAIL reset_hold got %b want 0", cpu_hold); else passed++;
    total++; if (ld_ack !== 1'b0) $display("FAIL reset_ack got %b want 0", ld_ack); else passed++;
    total++; if (imem_addr !== 2'd0) $display("FAIL reset_addr got %0d want 0", imem_addr); else passed++;
    total++; if (word_count !== 3'd0) $display("FAIL reset_count got %0d want 0", word_count); else passed++;
    total++; if (imem_wdata !== 32'h0) $display("FAIL reset_wdata got %h want 0", imem_wdata); else passed++;
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_two_words;
    int n0 = wd.size();
    int a0 = acks;
    start_session;
    total++; if (cpu_hold !== 1'b1) $display("FAIL tw_hold got %b want 1", cpu_hold); else passed++;
    send_word(32'h00000013);
    send_word(32'h00100093);
    tick(3);
    total++; if (wd.size() != n0 + 2) $display("FAIL tw_writes got %0d want 2", wd.size() - n0); else passed++;
    total++; if (wa_at(n0) !== 2'd0) $display("FAIL tw_addr0 got %0d want 0", wa_at(n0)); else passed++;
    total++; if (wd_at(n0) !== 32'h00000013) $display("FAIL tw_data0 got %h want 00000013", wd_at(n0)); else passed++;
    total++; if (wa_at(n0 + 1) !== 2'd1) $display("FAIL tw_addr1 got %0d want 1", wa_at(n0 + 1)); else passed++;
    total++; if (wd_at(n0 + 1) !== 32'h00100093) $display("FAIL tw_data1 got %h want 00100093", wd_at(n0 + 1)); else passed++;
    total++; if (word_count !== 3'd2) $display("FAIL tw_count got %0d want 2", word_count); else passed++;
    total++; if (acks - a0 != 8) $display("FAIL tw_acks got %0d want 8", acks - a0); else passed++;
    total++; if (imem_addr !== 2'd2) $display("FAIL tw_next_addr got %0d want 2", imem_addr); else passed++;
    total++; if (imem_wdata !== 32'h00100093) $display("FAIL tw_hold_wdata got %h want 00100093", imem_wdata); else passed++;
    end_session;
  endtask

  task automatic test_abort;
    int n0 = wd.size();
    int a0 = acks;
    start_session;
    send_byte(8'hAA);
    send_byte(8'hBB);
    total++; if (acks - a0 != 2) $display("FAIL ab_acks got %0d want 2", acks - a0); else passed++;
    ld_mode = 1'b0;
    tick(3);
    total++; if (cpu_hold !== 1'b1) $display("FAIL ab_hold_late got %b want 1", cpu_hold); else passed++;
    tick(1);
    total++; if (cpu_hold !== 1'b0) $display("FAIL ab_hold_fall got %b want 0", cpu_hold); else passed++;
    tick(2);
    total++; if (wd.size() != n0) $display("FAIL ab_no_write got %0d want 0", wd.size() - n0); else passed++;
    total++; if (word_count !== 3'd0) $display("FAIL ab_count got %0d want 0", word_count); else passed++;
    start_session;
    send_word(32'h04030201);
    tick(3);
    total++; if (wa_at(n0) !== 2'd0) $display("FAIL ab_next_addr got %0d want 0", wa_at(n0)); else passed++;
    total++; if (wd_at(n0) !== 32'h04030201) $display("FAIL ab_next_data got %h want 04030201", wd_at(n0)); else passed++;
    end_session;
  endtask

  task automatic test_wrap;
    int n0 = wd.size();
    logic [31:0] w;
    start_session;
    for (int i = 0; i < 5; i++) begin
      w = 32'h11111111 * (i + 1);
      send_word(w);
    end
    tick(3);
    total++; if (wd.size() != n0 + 5) $display("FAIL wr_writes got %0d want 5", wd.size() - n0); else passed++;
    for (int i = 0; i < 5; i++) begin
      w = 32'h11111111 * (i + 1);
      total++; if (wa_at(n0 + i) !== 2'(i % 4)) $display("FAIL wr_addr%0d got %0d want %0d", i, wa_at(n0 + i), i % 4); else passed++;
      total++; if (wd_at(n0 + i) !== w) $display("FAIL wr_data%0d got %h want %h", i, wd_at(n0 + i), w); else passed++;
    end
    total++; if (word_count !== 3'd4) $display("FAIL wr_count got %0d want 4", word_count); else passed++;
    total++; if (imem_addr !== 2'd1) $display("FAIL wr_next_addr got %0d want 1", imem_addr); else passed++;
    end_session;
  endtask

  task automatic test_mode_race;
    int n0;
    int a0;
    start_session;
    n0 = wd.size();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    a0 = acks;
    ld_data = 8'h44;
    ld_strobe = 1'b1;
    ld_mode = 1'b0;
    tick(6);
    total++; if (acks != a0) $display("FAIL mr_collect_ack got %0d toggles want 0", acks - a0); else passed++;
    total++; if (wd.size() != n0) $display("FAIL mr_collect_write got %0d want 0", wd.size() - n0); else passed++;
    total++; if (cpu_hold !== 1'b0) $display("FAIL mr_collect_hold got %b want 0", cpu_hold); else passed++;
    ld_strobe = 1'b0;
    tick(2);
    start_session;
    n0 = wd.size();
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    a0 = acks;
    ld_data = 8'hEF;
    ld_strobe = 1'b1;
    tick(1);
    ld_mode = 1'b0;
    tick(6);
    total++; if (wd.size() != n0 + 1) $display("FAIL mr_commit_write got %0d want 1", wd.size() - n0); else passed++;
    total++; if (wa_at(n0) !== 2'd0) $display("FAIL mr_commit_addr got %0d want 0", wa_at(n0)); else passed++;
    total++; if (wd_at(n0) !== 32'hEFBEADDE) $display("FAIL mr_commit_data got %h want efbeadde", wd_at(n0)); else passed++;
    total++; if (acks - a0 != 1) $display("FAIL mr_commit_ack got %0d want 1", acks - a0); else passed++;
    total++; if (word_count !== 3'd1) $display("FAIL mr_commit_count got %0d want 1", word_count); else passed++;
    total++; if (cpu_hold !== 1'b0) $display("FAIL mr_commit_hold got %b want 0", cpu_hold); else passed++;
    ld_strobe = 1'b0;
    tick(2);
  endtask

  task automatic test_ena;
    int n0;
    int a0;
    start_session;
    n0 = wd.size();
    send_byte(8'h78);
    send_byte(8'h56);
    a0 = acks;
    ena = 1'b0;
    ld_data = 8'hFF;
    ld_strobe = 1'b1;
    tick(3);
    ld_strobe = 1'b0;
    tick(3);
    total++; if (acks != a0) $display("FAIL en_frozen_ack got %0d toggles want 0", acks - a0); else passed++;
    total++; if (cpu_hold !== 1'b1) $display("FAIL en_frozen_hold got %b want 1", cpu_hold); else passed++;
    ena = 1'b1;
    tick(3);
    total++; if (acks != a0) $display("FAIL en_resume_ack got %0d toggles want 0", acks - a0); else passed++;
    send_byte(8'h34);
    send_byte(8'h12);
    tick(3);
    total++; if (wd.size() != n0 + 1) $display("FAIL en_writes got %0d want 1", wd.size() - n0); else passed++;
    total++; if (wd_at(n0) !== 32'h12345678) $display("FAIL en_data got %h want 12345678", wd_at(n0)); else passed++;
    end_session;
  endtask

  task automatic test_reset_mid;
    int n0;
    start_session;
    send_word(32'hCAFEF00D);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    total++; if (imem_addr !== 2'd1) $display("FAIL rm_pre_addr got %0d want 1", imem_addr); else passed++;
    n0 = wd.size();
    rst_n = 1'b0;
    tick(1);
    total++; if (imem_we !== 1'b0) $display("FAIL rm_we got %b want 0", imem_we); else passed++;
    total++; if (cpu_hold !== 1'b0) $display("FAIL rm_hold got %b want 0", cpu_hold); else passed++;
    total++; if (ld_ack !== 1'b0) $display("FAIL rm_ack got %b want 0", ld_ack); else passed++;
    total++; if (imem_addr !== 2'd0) $display("FAIL rm_addr got %0d want 0", imem_addr); else passed++;
    total++; if (word_count !== 3'd0) $display("FAIL rm_count got %0d want 0", word_count); else passed++;
    total++; if (imem_wdata !== 32'h0) $display("FAIL rm_wdata got %h want 0", imem_wdata); else passed++;
    rst_n = 1'b1;
    tick(5);
    total++; if (wd.size() != n0) $display("FAIL rm_no_write got %0d want 0", wd.size() - n0); else passed++;
    send_word(32'h0D0C0B0A);
    tick(3);
    total++; if (wa_at(n0) !== 2'd0) $display("FAIL rm_fresh_addr got %0d want 0", wa_at(n0)); else passed++;
    total++; if (wd_at(n0) !== 32'h0D0C0B0A) $display("FAIL rm_fresh_data got %h want 0d0c0b0a", wd_at(n0)); else passed++;
    end_session;
  endtask

  initial begin
    test_reset;
    test_two_words;
    test_abort;
    test_wrap;
    test_mode_race;
    test_ena;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed so far", passed, total);
    $fatal(1);
  end
endmodule
